spi_reram_slave: RTL and testbench

- SPI mode-0 responder: the ReRAM end of the link driven by the team's SPI write/read master.
- Oversamples SPI_SCLK, SPI_CSN and SPI_MOSI in the system clock domain and decodes command/address/data bytes.
- Turns each decoded byte into a single-cycle access on a synchronous byte-wide memory port; returns read data on SPI_MISO.
- Used as the bench-side and emulation-side ReRAM model for the master.

---
 rtl/spi_reram_slave.sv | 145 ++++++++++++++
 tb/tb_spi_reram_slave.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reram_slave.sv
// SPI mode-0 responder for a byte-wide synchronous ReRAM port.
// SPI pins are oversampled in the sclk domain, and each decoded byte becomes one memory strobe.
module spi_reram_slave #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter logic [7:0]  CMD_WR = 8'h02,
  parameter logic [7:0]  CMD_RD = 8'h03
) (
  input  logic              sclk,
  input  logic              srst,
  input  logic              SPI_SCLK,
  input  logic              SPI_CSN,
  input  logic              SPI_MOSI,
  output logic              SPI_MISO,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              wr_finish,
  output logic              rd_finish
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, IGNORE} state_t;

  state_t state, state_nxt;

  logic [2:0]        sck_sy, csn_sy;
  logic [1:0]        mosi_sy;
  logic [2:0]        bit_cnt;
  logic [DATA_W-1:0] shift_in, shift_out, rx_byte;
  logic              op_rd, load_q, wr_done, rd_done;
  logic              sck_rise, sck_fall, csn_rise, csn_fall, byte_done;

  // CSN history resets low so a select still held low across srst never looks like a new fall.
  always_ff @(posedge sclk or posedge srst) begin
    if (srst) begin
      sck_sy  <= '0;
      csn_sy  <= '0;
      mosi_sy <= '0;
    end else begin
      sck_sy  <= {sck_sy[1:0], SPI_SCLK};
      csn_sy  <= {csn_sy[1:0], SPI_CSN};
      mosi_sy <= {mosi_sy[0], SPI_MOSI};
    end
  end

  assign sck_rise  =  sck_sy[1] & ~sck_sy[2];
  assign sck_fall  = ~sck_sy[1] &  sck_sy[2];
  assign csn_rise  =  csn_sy[1] & ~csn_sy[2];
  assign csn_fall  = ~csn_sy[1] &  csn_sy[2];
  assign rx_byte   = {shift_in[DATA_W-2:0], mosi_sy[1]};
  assign byte_done = sck_rise && (bit_cnt == 3'd7);
  assign busy      = (state != IDLE);

  always_ff @(posedge sclk or posedge srst) begin
    if (srst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Reads go straight to RDATA; the prefetch finishes well before the first falling edge.
  always_comb begin
    state_nxt = state;
    if (csn_rise) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (csn_fall) state_nxt = CMD;
        CMD:     if (byte_done)
                   state_nxt = (rx_byte == CMD_WR || rx_byte == CMD_RD) ? ADDR : IGNORE;
        ADDR:    if (byte_done) state_nxt = op_rd ? RDATA : WDATA;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge sclk or posedge srst) begin
    if (srst) begin
      SPI_MISO  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      wr_finish <= 1'b0;
      rd_finish <= 1'b0;
      bit_cnt   <= '0;
      shift_in  <= '0;
      shift_out <= '0;
      op_rd     <= 1'b0;
      load_q    <= 1'b0;
      wr_done   <= 1'b0;
      rd_done   <= 1'b0;
    end else begin
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      wr_finish <= 1'b0;
      rd_finish <= 1'b0;
      load_q    <= mem_re;
      if (mem_we) mem_addr <= mem_addr + 1'b1;
      if (csn_rise) begin
        SPI_MISO  <= 1'b0;
        wr_finish <= wr_done;
        rd_finish <= rd_done;
        wr_done   <= 1'b0;
        rd_done   <= 1'b0;
      end else begin
        if (sck_rise && state != IDLE) begin
          bit_cnt  <= bit_cnt + 1'b1;
          shift_in <= rx_byte;
        end
        case (state)
          IDLE: begin
            SPI_MISO <= 1'b0;
            if (csn_fall) bit_cnt <= '0;
          end
          CMD:   if (byte_done) op_rd <= (rx_byte == CMD_RD);
          ADDR: if (byte_done) begin
            mem_addr <= ADDR_W'(rx_byte);
            mem_re   <= op_rd;
          end
          WDATA: if (byte_done) begin
            mem_we    <= 1'b1;
            mem_wdata <= rx_byte;
            wr_done   <= 1'b1;
          end
          RDATA: begin
            if (sck_fall) begin
              SPI_MISO  <= shift_out[DATA_W-1];
              shift_out <= {shift_out[DATA_W-2:0], 1'b0};
            end
            if (byte_done) begin
              mem_addr <= mem_addr + 1'b1;
              mem_re   <= 1'b1;
              rd_done  <= 1'b1;
            end
          end
          default: SPI_MISO <= 1'b0;
        endcase
      end
      if (load_q) shift_out <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_spi_reram_slave.sv
// Directed bench for spi_reram_slave: table-driven single-byte writes/reads plus multi-cycle corner sequences.
module tb_spi_reram_slave;

  logic       clk = 1'b0;
  logic       srst = 1'b1;
  logic       SPI_SCLK = 1'b0, SPI_CSN = 1'b1, SPI_MOSI = 1'b0;
  logic       SPI_MISO;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_we, mem_re, busy, wr_finish, rd_finish;

  logic [7:0] mem [256];

  int unsigned n_cmp = 0, n_err = 0;
  int unsigned wr_cnt = 0, rd_cnt = 0;
  logic        miso_seen = 1'b0;
  logic [7:0]  we_a[$], we_d[$], re_a[$];

  always #5 clk = ~clk;

  spi_reram_slave #(.ADDR_W(8), .DATA_W(8), .CMD_WR(8'h02), .CMD_RD(8'h03)) dut (
    .sclk(clk), .srst(srst), .SPI_SCLK(SPI_SCLK), .SPI_CSN(SPI_CSN), .SPI_MOSI(SPI_MOSI),
    .SPI_MISO(SPI_MISO), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata), .busy(busy), .wr_finish(wr_finish),
    .rd_finish(rd_finish)
  );

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  always @(negedge clk) begin
    if (mem_we) begin we_a.push_back(mem_addr); we_d.push_back(mem_wdata); end
    if (mem_re) re_a.push_back(mem_addr);
    if (wr_finish) wr_cnt++;
    if (rd_finish) rd_cnt++;
    if (SPI_MISO) miso_seen = 1'b1;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    we_a.delete(); we_d.delete(); re_a.delete();
    wr_cnt = 0; rd_cnt = 0; miso_seen = 1'b0;
  endtask

  task automatic half();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int unsigned n, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - int'(n); i--) begin
      SPI_MOSI = tx[i];
      half();
      rx[i] = SPI_MISO;
      SPI_SCLK = 1'b1;
      half();
      SPI_SCLK = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(tx, 8, rx);
  endtask

  task automatic cs_begin();
    SPI_CSN = 1'b0;
    half();
  endtask

  task automatic cs_end();
    half();
    SPI_CSN = 1'b1;
    repeat (8) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } vec_t;

  vec_t vecs [5];
  logic [7:0] rx, rx2;

  initial begin
    vecs[0] = '{addr: 8'h55, data: 8'hAA};
    vecs[1] = '{addr: 8'h00, data: 8'h01};
    vecs[2] = '{addr: 8'hFF, data: 8'h80};
    vecs[3] = '{addr: 8'h10, data: 8'h7E};
    vecs[4] = '{addr: 8'h3C, data: 8'hC3};
    foreach (mem[i]) mem[i] = '0;
    mem_rdata = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_miso", SPI_MISO, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_we_re", {mem_we, mem_re}, 2'b00);
    check("rst_fin", {wr_finish, rd_finish}, 2'b00);
    check("rst_addr_wdata", {mem_addr, mem_wdata}, 16'h0000);
    srst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("idle_busy", busy, 1'b0);

    // table: single-byte writes
    for (int i = 0; i < 5; i++) begin
      clear_log();
      cs_begin();
      spi_byte(8'h02, rx);
      spi_byte(vecs[i].addr, rx);
      spi_byte(vecs[i].data, rx);
      cs_end();
      check($sformatf("wr%0d_count", i), we_a.size(), 1);
      if (we_a.size() == 1) begin
        check($sformatf("wr%0d_addr", i), we_a[0], vecs[i].addr);
        check($sformatf("wr%0d_data", i), we_d[0], vecs[i].data);
      end
      check($sformatf("wr%0d_finish", i), wr_cnt, 1);
      check($sformatf("wr%0d_nord", i), rd_cnt, 0);
    end

    // table: single-byte reads of the same locations
    for (int i = 0; i < 5; i++) begin
      clear_log();
      cs_begin();
      spi_byte(8'h03, rx);
      spi_byte(vecs[i].addr, rx);
      spi_byte(8'h00, rx);
      cs_end();
      check($sformatf("rd%0d_miso", i), rx, vecs[i].data);
      if (re_a.size() > 0) check($sformatf("rd%0d_re_addr", i), re_a[0], vecs[i].addr);
      else check($sformatf("rd%0d_re_addr", i), 32'hFFFF_FFFF, vecs[i].addr);
      check($sformatf("rd%0d_finish", i), rd_cnt, 1);
      check($sformatf("rd%0d_nowr", i), wr_cnt + we_a.size(), 0);
    end

    // two-byte read burst
    mem[8'h55] = 8'hA5;
    mem[8'h56] = 8'h3C;
    clear_log();
    cs_begin();
    spi_byte(8'h03, rx);
    spi_byte(8'h55, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h00, rx2);
    cs_end();
    check("burst_rd_b0", rx, 8'hA5);
    check("burst_rd_b1", rx2, 8'h3C);
    check("burst_rd_re_cnt_ge2", re_a.size() >= 2, 1'b1);
    if (re_a.size() >= 2) begin
      check("burst_rd_re0", re_a[0], 8'h55);
      check("burst_rd_re1", re_a[1], 8'h56);
    end
    check("burst_rd_finish", rd_cnt, 1);
    check("burst_rd_miso_idle", SPI_MISO, 1'b0);

    // burst write with address wrap
    clear_log();
    cs_begin();
    spi_byte(8'h02, rx);
    spi_byte(8'hFE, rx);
    spi_byte(8'h11, rx);
    spi_byte(8'h22, rx);
    spi_byte(8'h33, rx);
    cs_end();
    check("wrap_count", we_a.size(), 3);
    if (we_a.size() == 3) begin
      check("wrap_a0", {we_a[0], we_d[0]}, 16'hFE11);
      check("wrap_a1", {we_a[1], we_d[1]}, 16'hFF22);
      check("wrap_a2", {we_a[2], we_d[2]}, 16'h0033);
    end
    check("wrap_finish", wr_cnt, 1);

    // abort after 5 data bits, then a normal write
    clear_log();
    cs_begin();
    spi_byte(8'h02, rx);
    spi_byte(8'h40, rx);
    spi_bits(8'hFF, 5, rx);
    cs_end();
    check("abort_no_we", we_a.size(), 0);
    check("abort_no_finish", wr_cnt, 0);
    check("abort_idle", busy, 1'b0);
    clear_log();
    cs_begin();
    spi_byte(8'h02, rx);
    spi_byte(8'h40, rx);
    spi_byte(8'h99, rx);
    cs_end();
    check("after_abort_we", we_a.size(), 1);
    if (we_a.size() == 1) check("after_abort_data", {we_a[0], we_d[0]}, 16'h4099);
    check("after_abort_finish", wr_cnt, 1);

    // unknown opcode
    clear_log();
    cs_begin();
    spi_byte(8'h9F, rx);
    spi_byte(8'hFF, rx);
    check("badop_busy_low_csn", busy, 1'b1);
    spi_byte(8'h55, rx);
    spi_byte(8'hFF, rx);
    cs_end();
    check("badop_no_strobe", we_a.size() + re_a.size(), 0);
    check("badop_miso_quiet", miso_seen, 1'b0);
    check("badop_no_finish", wr_cnt + rd_cnt, 0);
    check("badop_busy_high_csn", busy, 1'b0);

    // srst in the middle of a read data byte
    clear_log();
    cs_begin();
    spi_byte(8'h03, rx);
    spi_byte(8'h55, rx);
    spi_bits(8'h00, 3, rx);
    check("pre_srst_busy", busy, 1'b1);
    srst = 1'b1;
    #1;
    check("srst_miso", SPI_MISO, 1'b0);
    check("srst_busy", busy, 1'b0);
    SPI_CSN = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    srst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("srst_no_finish", rd_cnt + wr_cnt, 0);
    clear_log();
    cs_begin();
    spi_byte(8'h03, rx);
    spi_byte(8'h55, rx);
    spi_byte(8'h00, rx);
    cs_end();
    check("post_srst_read", rx, 8'hA5);
    check("post_srst_finish", rd_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
